// File: rtl/prog_loader.sv
// Boot loader: assembles a host byte stream (count, little-endian words, XOR checksum)
// into instruction RAM writes and releases the core from reset once the program verifies.
module prog_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_t          state;
  logic [1:0]      byte_cnt;
  logic [23:0]     word_reg;
  logic [7:0]      acc;
  logic [ADDR_W:0] n_reg;
  logic            take;
  logic [ADDR_W:0] wl_next;

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
  // byte_ready is low in WRITE, DONE, ERR and whenever rst is high.
  assign byte_ready = !rst && (state == S_IDLE || state == S_LOAD || state == S_CHECK);
  assign take       = byte_valid && byte_ready;
  assign wl_next    = words_loaded + 1'b1;
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_rst     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      byte_cnt     <= '0;
      word_reg     <= '0;
      acc          <= '0;
      n_reg        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            if (byte_data == 8'd0 || byte_data > DEPTH_B) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              n_reg    <= byte_data[ADDR_W:0];
              byte_cnt <= '0;
              acc      <= '0;
              state    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (take) begin
            acc      <= acc ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Fourth byte completes the word; it is written during the WRITE cycle.
              mem_we    <= 1'b1;
              mem_addr  <= words_loaded[ADDR_W-1:0];
              mem_wdata <= {byte_data, word_reg};
              state     <= S_WRITE;
            end else begin
              word_reg[{byte_cnt, 3'b000} +: 8] <= byte_data;
            end
          end
        end
        S_WRITE: begin
          mem_we       <= 1'b0;
          words_loaded <= wl_next;
          state        <= (wl_next == n_reg) ? S_CHECK : S_LOAD;
        end
        S_CHECK: begin
          if (take) begin
            if (byte_data == acc) begin
              state    <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        S_DONE: state <= S_DONE;
        S_ERR:  state <= S_ERR;
        default: begin
          state <= S_ERR;
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule
